instr_fetch: RTL and testbench

Instruction fetch unit for one processor core: the reader side of the instruction RAM. It drives word addresses into the single-port, 1-cycle-registered-read instruction RAM and assembles each instruction from an opcode word plus an optional operand word. It presents the instruction to the core's control unit over a valid/ready handshake and accepts branch redirects from the core. It stops on ENDOP.

---
 rtl/isa_pkg.sv | 41 ++++
 rtl/instr_fetch_if.sv | 39 +++
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the core: opcode encodings, the operand-length
// rule and the instruction fetch FSM state type. Used by the fetch unit, the
// control unit and the program loader in the testbench.
package isa_pkg;

    localparam int unsigned IsaWordW = 16;

    localparam logic [IsaWordW-1:0] OpLdac  = 16'd7;
    localparam logic [IsaWordW-1:0] OpStac  = 16'd11;
    localparam logic [IsaWordW-1:0] OpMvac  = 16'd15;
    localparam logic [IsaWordW-1:0] OpMvr   = 16'd16;
    localparam logic [IsaWordW-1:0] OpAdd   = 16'd17;
    localparam logic [IsaWordW-1:0] OpAddm  = 16'd19;
    localparam logic [IsaWordW-1:0] OpInac  = 16'd23;
    localparam logic [IsaWordW-1:0] OpSub   = 16'd24;
    localparam logic [IsaWordW-1:0] OpMul   = 16'd26;
    localparam logic [IsaWordW-1:0] OpMulm  = 16'd28;
    localparam logic [IsaWordW-1:0] OpClac  = 16'd32;
    localparam logic [IsaWordW-1:0] OpJump  = 16'd33;
    localparam logic [IsaWordW-1:0] OpJpnz  = 16'd35;
    localparam logic [IsaWordW-1:0] OpEndop = 16'd40;
    localparam logic [IsaWordW-1:0] OpNop   = 16'd41;

    typedef enum logic [2:0] {
        StIdle,
        StOpAddr,
        StOpData,
        StArgAddr,
        StArgData,
        StOffer,
        StHalt
    } fetch_state_e;

    // Opcodes followed by an operand word; anything else (unknown values
    // included) is a single-word instruction.
    function automatic logic has_operand(input logic [IsaWordW-1:0] opcode);
        return (opcode == OpLdac) || (opcode == OpStac) ||
               (opcode == OpJump) || (opcode == OpJpnz);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle between the instruction fetch unit, the instruction RAM and the
// core control unit.
//   start / start_pc          : launch fetching (control -> fetch)
//   iram_addr / iram_data     : word address out, registered read data back
//   instr_valid / instr_ready : instruction handshake (fetch -> control)
//   instr_opcode/operand/pc   : instruction payload
//   redirect / redirect_pc    : fetch restart from a taken branch
//   halted / busy             : fetch unit status
// master = fetch unit side, slave = RAM/control side.
interface instr_fetch_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          start;
    logic [AW-1:0] start_pc;
    logic [AW-1:0] iram_addr;
    logic [DW-1:0] iram_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_opcode;
    logic [DW-1:0] instr_operand;
    logic [AW-1:0] instr_pc;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halted;
    logic          busy;

    modport master (
        input  start, start_pc, iram_data, instr_ready, redirect, redirect_pc,
        output iram_addr, instr_valid, instr_opcode, instr_operand, instr_pc,
               halted, busy
    );

    modport slave (
        output start, start_pc, iram_data, instr_ready, redirect, redirect_pc,
        input  iram_addr, instr_valid, instr_opcode, instr_operand, instr_pc,
               halted, busy
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Reads opcode words (and the operand word of
// two-word opcodes) from a 1-cycle registered-read instruction RAM, offers the
// assembled instruction to the core over valid/ready, restarts on branch
// redirects and stops after ENDOP has been consumed.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : instr_fetch_if master modport (RAM, handshake, redirect, status)
// Every output is a register; no input reaches an output combinationally.
module instr_fetch
    import isa_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);

    fetch_state_e  state;
    logic [AW-1:0] pc;          // address of the opcode being fetched/offered
    logic [AW-1:0] fetch_addr;  // address currently presented to the RAM
    logic [DW-1:0] opcode;
    logic [DW-1:0] operand;
    logic          valid;
    logic          halt_flag;
    logic          busy_flag;   // mirrors "state is neither idle nor halt"

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            pc         <= '0;
            fetch_addr <= '0;
            opcode     <= '0;
            operand    <= '0;
            valid      <= 1'b0;
            halt_flag  <= 1'b0;
            busy_flag  <= 1'b0;
        end else if (bus.redirect && busy_flag) begin
            // Redirect beats every other transition. Any word in flight is
            // dropped; an offer accepted at this edge still completes since
            // the core has taken it, only the next fetch address changes.
            pc         <= bus.redirect_pc;
            fetch_addr <= bus.redirect_pc;
            valid      <= 1'b0;
            state      <= StOpAddr;
        end else begin
            unique case (state)
                StIdle, StHalt: begin
                    if (bus.start) begin
                        pc         <= bus.start_pc;
                        fetch_addr <= bus.start_pc;
                        halt_flag  <= 1'b0;
                        busy_flag  <= 1'b1;
                        state      <= StOpAddr;
                    end
                end
                StOpAddr: begin
                    state <= StOpData;
                end
                StOpData: begin
                    opcode <= bus.iram_data;
                    if (has_operand(bus.iram_data)) begin
                        // Natural AW-bit wrap: operand of 0xFFFF comes from 0.
                        fetch_addr <= pc + AW'(1);
                        state      <= StArgAddr;
                    end else begin
                        operand <= '0;
                        valid   <= 1'b1;
                        state   <= StOffer;
                    end
                end
                StArgAddr: begin
                    state <= StArgData;
                end
                StArgData: begin
                    operand <= bus.iram_data;
                    valid   <= 1'b1;
                    state   <= StOffer;
                end
                StOffer: begin
                    if (bus.instr_ready) begin
                        valid      <= 1'b0;
                        pc         <= pc + (has_operand(opcode) ? AW'(2) : AW'(1));
                        fetch_addr <= pc + (has_operand(opcode) ? AW'(2) : AW'(1));
                        if (opcode == OpEndop) begin
                            halt_flag <= 1'b1;
                            busy_flag <= 1'b0;
                            state     <= StHalt;
                        end else begin
                            state <= StOpAddr;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.iram_addr     = fetch_addr;
    assign bus.instr_valid   = valid;
    assign bus.instr_opcode  = opcode;
    assign bus.instr_operand = operand;
    assign bus.instr_pc      = pc;
    assign bus.halted        = halt_flag;
    assign bus.busy          = busy_flag;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a directed program built from the ISA
// package, plus randomized programs, backpressure and redirects, checked
// against a behavioural model of what the fetch unit should offer.
module tb_instr_fetch;
    import isa_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_if #(.AW(16), .DW(16)) bus ();

    instr_fetch #(.AW(16), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction RAM: one-cycle registered read.
    logic [15:0] mem [0:65535];
    always @(posedge clk) bus.iram_data <= mem[bus.iram_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    function automatic bit two_word(input logic [15:0] op);
        return (op == 16'd7) || (op == 16'd11) || (op == 16'd33) || (op == 16'd35);
    endfunction

    function automatic logic [15:0] ref_operand(input logic [15:0] pc);
        logic [15:0] a;
        a = pc + 16'd1;
        return two_word(mem[pc]) ? mem[a] : 16'd0;
    endfunction

    function automatic logic [15:0] ref_next(input logic [15:0] pc);
        return pc + (two_word(mem[pc]) ? 16'd2 : 16'd1);
    endfunction

    function automatic int ref_lat(input logic [15:0] pc);
        return two_word(mem[pc]) ? 4 : 2;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (bus.instr_valid === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic do_start(input logic [15:0] spc);
        bus.start    = 1'b1;
        bus.start_pc = spc;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic accept(input logic redir, input logic [15:0] rpc);
        bus.instr_ready = 1'b1;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        tick();
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({bus.iram_addr, bus.instr_valid, bus.instr_opcode, bus.instr_operand,
             bus.instr_pc, bus.halted, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%0h v=%b op=%0d opr=%0d pc=%0h h=%b b=%b, want all 0",
                     bus.iram_addr, bus.instr_valid, bus.instr_opcode, bus.instr_operand,
                     bus.instr_pc, bus.halted, bus.busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: valid=%b busy=%b, want 0 0", bus.instr_valid, bus.busy);
        end
    endtask

    task automatic test_basic();
        int c;
        do_start(16'd0);
        n_checks++;
        if (bus.iram_addr !== 16'd0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_addr: addr=%0d busy=%b, want 0 1", bus.iram_addr, bus.busy);
        end
        wait_valid(10, c);
        n_checks++;
        if (c !== 2) begin
            n_fail++;
            $display("FAIL clac_latency: got %0d, want 2", c);
        end
        n_checks++;
        if (bus.instr_opcode !== 16'd32 || bus.instr_operand !== 16'd0 || bus.instr_pc !== 16'd0) begin
            n_fail++;
            $display("FAIL clac_payload: op=%0d opr=%0d pc=%0d, want 32 0 0",
                     bus.instr_opcode, bus.instr_operand, bus.instr_pc);
        end
        accept(1'b0, 16'd0);
        n_checks++;
        if (bus.instr_valid !== 1'b0 || bus.iram_addr !== 16'd1) begin
            n_fail++;
            $display("FAIL clac_transfer: valid=%b addr=%0d, want 0 1", bus.instr_valid, bus.iram_addr);
        end
        wait_valid(10, c);
        n_checks++;
        if (c !== 4) begin
            n_fail++;
            $display("FAIL stac_latency: got %0d, want 4", c);
        end
        n_checks++;
        if (bus.instr_opcode !== 16'd11 || bus.instr_operand !== 16'd65400 || bus.instr_pc !== 16'd1) begin
            n_fail++;
            $display("FAIL stac_payload: op=%0d opr=%0d pc=%0d, want 11 65400 1",
                     bus.instr_opcode, bus.instr_operand, bus.instr_pc);
        end
    endtask

    task automatic test_backpressure();
        int c;
        accept(1'b0, 16'd0);
        wait_valid(10, c);
        n_checks++;
        if (c !== 4 || bus.instr_opcode !== 16'd7 || bus.instr_operand !== 16'd65401 ||
            bus.instr_pc !== 16'd3) begin
            n_fail++;
            $display("FAIL ldac_offer: lat=%0d op=%0d opr=%0d pc=%0d, want 4 7 65401 3",
                     c, bus.instr_opcode, bus.instr_operand, bus.instr_pc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_opcode !== 16'd7 ||
                bus.instr_operand !== 16'd65401 || bus.instr_pc !== 16'd3 ||
                bus.iram_addr !== 16'd4) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: v=%b op=%0d opr=%0d pc=%0d addr=%0d, want 1 7 65401 3 4",
                         i, bus.instr_valid, bus.instr_opcode, bus.instr_operand, bus.instr_pc,
                         bus.iram_addr);
            end
        end
        accept(1'b0, 16'd0);
        n_checks++;
        if (bus.instr_valid !== 1'b0 || bus.iram_addr !== 16'd5) begin
            n_fail++;
            $display("FAIL bp_transfer: valid=%b addr=%0d, want 0 5", bus.instr_valid, bus.iram_addr);
        end
        wait_valid(10, c);
        n_checks++;
        if (c !== 4 || bus.instr_pc !== 16'd5 || bus.instr_opcode !== 16'd7) begin
            n_fail++;
            $display("FAIL bp_next: lat=%0d pc=%0d op=%0d, want 4 5 7", c, bus.instr_pc, bus.instr_opcode);
        end
    endtask

    task automatic test_redirect();
        int c;
        logic [15:0] e;
        e = 16'd5;
        for (int n = 0; n < 20 && e != 16'd19; n++) begin
            accept(1'b0, 16'd0);
            e = ref_next(e);
            wait_valid(10, c);
            n_checks++;
            if (c !== ref_lat(e) || bus.instr_opcode !== mem[e] ||
                bus.instr_operand !== ref_operand(e) || bus.instr_pc !== e) begin
                n_fail++;
                $display("FAIL walk_offer: lat=%0d op=%0d opr=%0d pc=%0d, want %0d %0d %0d %0d",
                         c, bus.instr_opcode, bus.instr_operand, bus.instr_pc,
                         ref_lat(e), mem[e], ref_operand(e), e);
            end
        end
        n_checks++;
        if (bus.instr_opcode !== 16'd35 || bus.instr_operand !== 16'd5 || bus.instr_pc !== 16'd19) begin
            n_fail++;
            $display("FAIL jpnz_offer: op=%0d opr=%0d pc=%0d, want 35 5 19",
                     bus.instr_opcode, bus.instr_operand, bus.instr_pc);
        end
        accept(1'b1, 16'd5);
        n_checks++;
        if (bus.instr_valid !== 1'b0 || bus.iram_addr !== 16'd5) begin
            n_fail++;
            $display("FAIL redirect_edge: valid=%b addr=%0d, want 0 5", bus.instr_valid, bus.iram_addr);
        end
        wait_valid(10, c);
        n_checks++;
        if (c !== 4 || bus.instr_opcode !== 16'd7 || bus.instr_operand !== 16'd65401 ||
            bus.instr_pc !== 16'd5) begin
            n_fail++;
            $display("FAIL redirect_target: lat=%0d op=%0d opr=%0d pc=%0d, want 4 7 65401 5",
                     c, bus.instr_opcode, bus.instr_operand, bus.instr_pc);
        end
        // Next is JUMP,12 at 7; redirect while its operand is being read.
        accept(1'b0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL partial_no_valid[%0d]: valid=%b, want 0", i, bus.instr_valid);
            end
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'd21;
        tick();
        bus.redirect    = 1'b0;
        n_checks++;
        if (bus.instr_valid !== 1'b0 || bus.iram_addr !== 16'd21) begin
            n_fail++;
            $display("FAIL argdata_redirect: valid=%b addr=%0d, want 0 21", bus.instr_valid, bus.iram_addr);
        end
        wait_valid(10, c);
        n_checks++;
        if (c !== 2 || bus.instr_pc !== 16'd21 || bus.instr_opcode !== 16'd41) begin
            n_fail++;
            $display("FAIL partial_dropped: lat=%0d pc=%0d op=%0d, want 2 21 41",
                     c, bus.instr_pc, bus.instr_opcode);
        end
    endtask

    task automatic test_halt();
        int c;
        logic [15:0] e;
        e = 16'd21;
        for (int n = 0; n < 10 && e != 16'd25; n++) begin
            accept(1'b0, 16'd0);
            e = ref_next(e);
            wait_valid(10, c);
            n_checks++;
            if (c !== ref_lat(e) || bus.instr_opcode !== mem[e] ||
                bus.instr_operand !== ref_operand(e) || bus.instr_pc !== e) begin
                n_fail++;
                $display("FAIL tail_offer: lat=%0d op=%0d opr=%0d pc=%0d, want %0d %0d %0d %0d",
                         c, bus.instr_opcode, bus.instr_operand, bus.instr_pc,
                         ref_lat(e), mem[e], ref_operand(e), e);
            end
        end
        n_checks++;
        if (bus.instr_opcode !== 16'd40 || bus.instr_pc !== 16'd25) begin
            n_fail++;
            $display("FAIL endop_offer: op=%0d pc=%0d, want 40 25", bus.instr_opcode, bus.instr_pc);
        end
        accept(1'b0, 16'd0);
        n_checks++;
        if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.instr_valid !== 1'b0 ||
            bus.iram_addr !== 16'd26) begin
            n_fail++;
            $display("FAIL halt_entry: h=%b b=%b v=%b addr=%0d, want 1 0 0 26",
                     bus.halted, bus.busy, bus.instr_valid, bus.iram_addr);
        end
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.iram_addr !== 16'd26) begin
                n_fail++;
                $display("FAIL halt_frozen[%0d]: h=%b v=%b addr=%0d, want 1 0 26",
                         i, bus.halted, bus.instr_valid, bus.iram_addr);
            end
        end
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        do_start(16'd0);
        n_checks++;
        if (bus.halted !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_status: h=%b b=%b, want 0 1", bus.halted, bus.busy);
        end
        wait_valid(10, c);
        n_checks++;
        if (c !== 2 || bus.instr_opcode !== 16'd32 || bus.instr_pc !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_clac: lat=%0d op=%0d pc=%0d, want 2 32 0", c, bus.instr_opcode, bus.instr_pc);
        end
    endtask

    task automatic test_wrap();
        int c;
        pulse_reset();
        mem[16'hFFFF] = OpLdac;
        mem[16'h0000] = 16'h1234;
        do_start(16'hFFFF);
        wait_valid(10, c);
        n_checks++;
        if (c !== 4 || bus.instr_opcode !== 16'd7 || bus.instr_operand !== 16'h1234 ||
            bus.instr_pc !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_offer: lat=%0d op=%0d opr=%0h pc=%0h, want 4 7 1234 ffff",
                     c, bus.instr_opcode, bus.instr_operand, bus.instr_pc);
        end
        accept(1'b0, 16'd0);
        n_checks++;
        if (bus.iram_addr !== 16'd1) begin
            n_fail++;
            $display("FAIL wrap_next_addr: addr=%0h, want 1", bus.iram_addr);
        end
        wait_valid(10, c);
        n_checks++;
        if (c !== ref_lat(16'd1) || bus.instr_pc !== 16'd1 || bus.instr_opcode !== mem[1]) begin
            n_fail++;
            $display("FAIL wrap_next_offer: lat=%0d pc=%0h op=%0d, want %0d 1 %0d",
                     c, bus.instr_pc, bus.instr_opcode, ref_lat(16'd1), mem[1]);
        end
    endtask

    task automatic test_random();
        logic [15:0] ops [14] = '{16'd41, 16'd7, 16'd11, 16'd15, 16'd16, 16'd17, 16'd19,
                                  16'd23, 16'd24, 16'd26, 16'd28, 16'd32, 16'd33, 16'd35};
        logic [15:0] e;
        logic [15:0] tgt;
        logic        redir;
        int          c;
        int          bp;
        pulse_reset();
        // ENDOP (40) never appears so the run cannot halt part-way.
        for (int a = 16'h1000; a < 16'h1200; a++) begin
            if ($urandom_range(0, 7) == 0) mem[a] = 16'($urandom_range(42, 999));
            else                           mem[a] = ops[$urandom_range(0, 13)];
        end
        do_start(16'h1000);
        e = 16'h1000;
        for (int n = 0; n < 80; n++) begin
            wait_valid(10, c);
            n_checks++;
            if (c !== ref_lat(e) || bus.instr_opcode !== mem[e] ||
                bus.instr_operand !== ref_operand(e) || bus.instr_pc !== e) begin
                n_fail++;
                $display("FAIL rand_offer[%0d]: lat=%0d op=%0d opr=%0d pc=%0h, want %0d %0d %0d %0h",
                         n, c, bus.instr_opcode, bus.instr_operand, bus.instr_pc,
                         ref_lat(e), mem[e], ref_operand(e), e);
            end
            bp = $urandom_range(0, 3);
            for (int i = 0; i < bp; i++) begin
                tick();
                n_checks++;
                if (bus.instr_valid !== 1'b1 || bus.instr_opcode !== mem[e] ||
                    bus.instr_operand !== ref_operand(e) || bus.instr_pc !== e) begin
                    n_fail++;
                    $display("FAIL rand_hold[%0d]: v=%b op=%0d opr=%0d pc=%0h, want 1 %0d %0d %0h",
                             n, bus.instr_valid, bus.instr_opcode, bus.instr_operand, bus.instr_pc,
                             mem[e], ref_operand(e), e);
                end
            end
            redir = ($urandom_range(0, 3) == 0);
            tgt   = 16'h1000 + 16'($urandom_range(0, 255));
            accept(redir, tgt);
            e = redir ? tgt : ref_next(e);
            n_checks++;
            if (bus.instr_valid !== 1'b0 || bus.iram_addr !== e) begin
                n_fail++;
                $display("FAIL rand_transfer[%0d]: v=%b addr=%0h, want 0 %0h",
                         n, bus.instr_valid, bus.iram_addr, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        pulse_reset();
        do_start(16'd1);          // STAC,65400: two-word
        tick();                   // OP_DATA
        tick();                   // ARG_ADDR
        tick();                   // ARG_DATA
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.iram_addr, bus.instr_valid, bus.instr_opcode, bus.instr_operand,
             bus.instr_pc, bus.halted, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: addr=%0h v=%b op=%0d opr=%0d pc=%0h h=%b b=%b, want all 0",
                     bus.iram_addr, bus.instr_valid, bus.instr_opcode, bus.instr_operand,
                     bus.instr_pc, bus.halted, bus.busy);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle[%0d]: v=%b b=%b, want 0 0", i, bus.instr_valid, bus.busy);
            end
        end
        do_start(16'd0);
        wait_valid(10, c);
        n_checks++;
        if (c !== ref_lat(16'd0) || bus.instr_opcode !== mem[0] ||
            bus.instr_operand !== ref_operand(16'd0) || bus.instr_pc !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_start: lat=%0d op=%0h opr=%0h pc=%0h, want %0d %0h %0h 0",
                     c, bus.instr_opcode, bus.instr_operand, bus.instr_pc,
                     ref_lat(16'd0), mem[0], ref_operand(16'd0));
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.start_pc    = '0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        for (int a = 0; a < 65536; a++) mem[a] = OpNop;
        mem[0]  = OpClac;
        mem[1]  = OpStac;  mem[2]  = 16'd65400;
        mem[3]  = OpLdac;  mem[4]  = 16'd65401;
        mem[5]  = OpLdac;  mem[6]  = 16'd65401;
        mem[7]  = OpJump;  mem[8]  = 16'd12;
        mem[9]  = OpAdd;   mem[10] = OpInac;  mem[11] = OpSub;   mem[12] = OpMul;
        mem[13] = 16'd99;  mem[14] = OpMvac;  mem[15] = OpAddm;  mem[16] = OpMulm;
        mem[17] = OpClac;  mem[18] = OpNop;
        mem[19] = OpJpnz;  mem[20] = 16'd5;
        mem[21] = OpNop;   mem[22] = OpMvr;   mem[23] = 16'd200; mem[24] = OpMul;
        mem[25] = OpEndop;

        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_random();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
